exu2lsu: RTL



---
 rtl/e2l_pkg.sv | 74 +++++++
 rtl/stage_skid_buf.sv | 113 +++++++++++
 rtl/exu2lsu.sv | 87 ++++++++
 3 files changed

// File: rtl/e2l_pkg.sv
// ---------------------------------------------------------------------------
// e2l_pkg
// Shared types and constants for the EXU-to-LSU pipeline stage.
//   - Default core-wide width/reset macros (used only when the surrounding
//     build has not already defined them).
//   - e2l_payload_t     : every field that travels from EXU to LSU.
//   - e2l_state_t       : occupancy of the two-entry skid buffer.
//   - E2L_PAYLOAD_RESET : value loaded into the payload registers on reset.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
  `define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
  `define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
  `define ARGS_WIDTH 8
`endif
`ifndef GPRS_WIDTH
  `define GPRS_WIDTH 5
`endif
`ifndef ADDR_INIT
  `define ADDR_INIT 32'h8000_0000
`endif
`ifndef INST_NAME_X
  `define INST_NAME_X 8'h00
`endif
`ifndef RAM_BYT_X
  `define RAM_BYT_X 8'h00
`endif
`ifndef REG_WR_SRC_X
  `define REG_WR_SRC_X 8'h00
`endif

package e2l_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int ARGS_W = `ARGS_WIDTH;
  localparam int GPRS_W = `GPRS_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ARGS_W-1:0] inst_name;
    logic              ram_wr_en;
    logic [ARGS_W-1:0] ram_byt;
    logic              reg_wr_en;
    logic [ARGS_W-1:0] reg_wr_src;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rs2_data;
    logic [GPRS_W-1:0] gpr_rd_id;
    logic [DATA_W-1:0] jmp_or_reg_data;
  } e2l_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main entry invalid
    ONE   = 2'd1,  // main valid, skid empty
    FULL  = 2'd2   // main and skid both valid
  } e2l_state_t;

  localparam e2l_payload_t E2L_PAYLOAD_RESET = '{
    pc:              ADDR_W'(`ADDR_INIT),
    inst_name:       ARGS_W'(`INST_NAME_X),
    ram_wr_en:       1'b0,
    ram_byt:         ARGS_W'(`RAM_BYT_X),
    reg_wr_en:       1'b0,
    reg_wr_src:      ARGS_W'(`REG_WR_SRC_X),
    alu_res:         '0,
    rs2_data:        '0,
    gpr_rd_id:       '0,
    jmp_or_reg_data: '0
  };

endpackage : e2l_pkg

// File: rtl/stage_skid_buf.sv
// ---------------------------------------------------------------------------
// stage_skid_buf
// Generic two-entry skid buffer for a valid/ready pipeline stage.
// The main entry drives the outputs; the skid entry absorbs the one extra
// item that can arrive in the cycle the consumer stalls, because in_ready is
// registered and therefore lags the downstream ready by one cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous, top priority; empties the buffer
//   in_valid / in_ready  : upstream handshake (in_ready is a flop output)
//   in_data              : upstream payload
//   out_valid/out_ready  : downstream handshake (out_valid is a flop output)
//   out_data             : downstream payload (main entry)
// ---------------------------------------------------------------------------
module stage_skid_buf
  import e2l_pkg::*;
#(
  parameter type      payload_t = logic,
  parameter payload_t RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  e2l_state_t state_q, state_d;
  payload_t   main_q,  main_d;
  payload_t   skid_q,  skid_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid  && ready_q;
  assign out_fire = valid_q   && out_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so nothing new can enter; skid drains first.
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything held and any simultaneous input. A simultaneous
    // out_fire has already been taken by the consumer. Payload is left as-is;
    // valid going low is what retires it.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      // NOTE: the payload entries are reset too, so the output fields show a
      // defined value straight out of reset instead of X.
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule : stage_skid_buf

// File: rtl/exu2lsu.sv
// ---------------------------------------------------------------------------
// exu2lsu
// EXU-to-LSU pipeline register with full valid/ready backpressure and a
// synchronous flush for branch redirection. Packs the EXU fields into
// e2l_payload_t, passes them through a two-entry skid buffer and unpacks
// them onto the LSU-side ports bit-exact.
//   i_sys_clk, i_sys_rst_n        : clock, asynchronous active-low reset
//   i_exu_valid / o_e2l_ready     : upstream handshake (ready is registered)
//   o_e2l_valid / i_lsu_ready     : downstream handshake
//   i_flush                       : drop all held instructions
//   i_exu_* / o_e2l_*             : instruction payload fields
// ---------------------------------------------------------------------------
module exu2lsu
  import e2l_pkg::*;
(
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_exu_valid,
  output logic              o_e2l_ready,
  input  logic              i_lsu_ready,
  output logic              o_e2l_valid,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_exu_pc,
  input  logic [ARGS_W-1:0] i_exu_ctr_inst_name,
  input  logic              i_exu_ctr_ram_wr_en,
  input  logic [ARGS_W-1:0] i_exu_ctr_ram_byt,
  input  logic              i_exu_ctr_reg_wr_en,
  input  logic [ARGS_W-1:0] i_exu_ctr_reg_wr_src,
  input  logic [DATA_W-1:0] i_exu_alu_res,
  input  logic [DATA_W-1:0] i_exu_rs2_data,
  input  logic [GPRS_W-1:0] i_exu_gpr_rd_id,
  input  logic [DATA_W-1:0] i_exu_jmp_or_reg_data,
  output logic [ADDR_W-1:0] o_e2l_pc,
  output logic [ARGS_W-1:0] o_e2l_ctr_inst_name,
  output logic              o_e2l_ctr_ram_wr_en,
  output logic [ARGS_W-1:0] o_e2l_ctr_ram_byt,
  output logic              o_e2l_ctr_reg_wr_en,
  output logic [ARGS_W-1:0] o_e2l_ctr_reg_wr_src,
  output logic [DATA_W-1:0] o_e2l_alu_res,
  output logic [DATA_W-1:0] o_e2l_rs2_data,
  output logic [GPRS_W-1:0] o_e2l_gpr_rd_id,
  output logic [DATA_W-1:0] o_e2l_jmp_or_reg_data
);

  e2l_payload_t in_payload;
  e2l_payload_t out_payload;

  assign in_payload = '{
    pc:              i_exu_pc,
    inst_name:       i_exu_ctr_inst_name,
    ram_wr_en:       i_exu_ctr_ram_wr_en,
    ram_byt:         i_exu_ctr_ram_byt,
    reg_wr_en:       i_exu_ctr_reg_wr_en,
    reg_wr_src:      i_exu_ctr_reg_wr_src,
    alu_res:         i_exu_alu_res,
    rs2_data:        i_exu_rs2_data,
    gpr_rd_id:       i_exu_gpr_rd_id,
    jmp_or_reg_data: i_exu_jmp_or_reg_data
  };

  stage_skid_buf #(
    .payload_t (e2l_payload_t),
    .RESET_VAL (E2L_PAYLOAD_RESET)
  ) u_skid (
    .clk       (i_sys_clk),
    .rst_n     (i_sys_rst_n),
    .flush     (i_flush),
    .in_valid  (i_exu_valid),
    .in_ready  (o_e2l_ready),
    .in_data   (in_payload),
    .out_valid (o_e2l_valid),
    .out_ready (i_lsu_ready),
    .out_data  (out_payload)
  );

  assign o_e2l_pc              = out_payload.pc;
  assign o_e2l_ctr_inst_name   = out_payload.inst_name;
  assign o_e2l_ctr_ram_wr_en   = out_payload.ram_wr_en;
  assign o_e2l_ctr_ram_byt     = out_payload.ram_byt;
  assign o_e2l_ctr_reg_wr_en   = out_payload.reg_wr_en;
  assign o_e2l_ctr_reg_wr_src  = out_payload.reg_wr_src;
  assign o_e2l_alu_res         = out_payload.alu_res;
  assign o_e2l_rs2_data        = out_payload.rs2_data;
  assign o_e2l_gpr_rd_id       = out_payload.gpr_rd_id;
  assign o_e2l_jmp_or_reg_data = out_payload.jmp_or_reg_data;

endmodule : exu2lsu
